// File: rtl/flash_erase_rsp.sv
// ---------------------------------------------------------------------------
// flash_erase_rsp
//
// Flash-side responder for erase requests. A level request (page or bank
// erase plus base word address) is checked when it is accepted. A legal
// request is carried out by writing all-ones to every word of the target
// page or bank through a single-port array write interface. The request
// completes with a one-cycle done_o or err_o pulse while req_i is still
// held, and the block then waits for req_i to drop before it accepts again.
//
// Optional feature (compile-time macro FLASH_ERASE_VERIFY_EN):
//   When defined, a VERIFY pass re-reads all erased words after the writes.
//   The first word that does not read back as all-ones ends the erase with
//   err_o.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   erase_en_i      erase permission, sampled only when a request is accepted
//   req_i           erase request level
//   op_i            0 = page erase, 1 = bank erase
//   addr_i          base word address of the page or bank
//   done_o, err_o   one-cycle completion / rejection pulses
//   busy_o          high whenever the block is not idle
//   mem_req_o       array access request
//   mem_we_o        1 = write, 0 = read
//   mem_addr_o      array word address
//   mem_wdata_o     array write data (always all-ones)
//   mem_gnt_i       array accepts the access this cycle
//   mem_rdata_i     array read data, valid the cycle after a granted read
// ---------------------------------------------------------------------------
module flash_erase_rsp #(
    parameter int AddrW        = 17,
    parameter int DataW        = 32,
    parameter int NumBanks     = 2,
    parameter int PagesPerBank = 256,
    parameter int WordsPerPage = 256
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             erase_en_i,
    input  logic             req_i,
    input  logic             op_i,
    input  logic [AddrW-1:0] addr_i,
    output logic             done_o,
    output logic             err_o,
    output logic             busy_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [AddrW-1:0] mem_addr_o,
    output logic [DataW-1:0] mem_wdata_o,
    input  logic             mem_gnt_i,
    input  logic [DataW-1:0] mem_rdata_i
);

    localparam int PageBits = $clog2(WordsPerPage);
    localparam int BankBits = $clog2(PagesPerBank * WordsPerPage);

    // Compared two bits wider than the address so the full array size never
    // overflows the comparison.
    localparam logic [AddrW+1:0] TotalWords =
        (AddrW+2)'(NumBanks * PagesPerBank * WordsPerPage);

    // Index of the final word of a page or a bank.
    localparam logic [AddrW:0] PageLast = (AddrW+1)'(WordsPerPage - 1);
    localparam logic [AddrW:0] BankLast = (AddrW+1)'(PagesPerBank * WordsPerPage - 1);

`ifdef FLASH_ERASE_VERIFY_EN
    typedef enum logic [2:0] {IDLE, WRITE, VERIFY, DONE, ERR, WAIT_REL} state_t;
`else
    typedef enum logic [2:0] {IDLE, WRITE, DONE, ERR, WAIT_REL} state_t;
`endif

    state_t           state;
    logic [AddrW-1:0] base;
    logic [AddrW:0]   count;
    logic [AddrW:0]   count_inc;
    logic [AddrW:0]   last;
    logic             mem_req_q;

    logic page_misaligned;
    logic bank_misaligned;
    logic out_of_range;
    logic reject;

    assign page_misaligned = (op_i == 1'b0) && (addr_i[PageBits-1:0] != '0);
    assign bank_misaligned = op_i && (addr_i[BankBits-1:0] != '0);
    assign out_of_range    = {2'b00, addr_i} >= TotalWords;
    assign reject          = !erase_en_i || page_misaligned || bank_misaligned || out_of_range;

    assign count_inc   = count + 1'b1;
    assign mem_wdata_o = '1;

`ifdef FLASH_ERASE_VERIFY_EN
    logic chk_valid;
    logic chk_last;
    logic rd_fail;

    // Read data is checked in the cycle it arrives. On a mismatch the read
    // already being offered for the next word is withdrawn in that same cycle,
    // so no word past the failing one is ever read.
    assign rd_fail   = chk_valid && (mem_rdata_i != '1);
    assign mem_req_o = mem_req_q && !rd_fail;
`else
    logic [DataW-1:0] unused_rdata;

    assign unused_rdata = mem_rdata_i;
    assign mem_req_o    = mem_req_q;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            base       <= '0;
            count      <= '0;
            last       <= '0;
            mem_req_q  <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= '0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            busy_o     <= 1'b0;
`ifdef FLASH_ERASE_VERIFY_EN
            chk_valid  <= 1'b0;
            chk_last   <= 1'b0;
`endif
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_i) begin
                        busy_o <= 1'b1;
                        base   <= addr_i;
                        count  <= '0;
                        last   <= op_i ? BankLast : PageLast;
                        if (reject) begin
                            err_o <= 1'b1;
                            state <= ERR;
                        end else begin
                            mem_req_q  <= 1'b1;
                            mem_we_o   <= 1'b1;
                            mem_addr_o <= addr_i;
                            state      <= WRITE;
                        end
                    end
                end

                // The address advances only on a grant, so a stalled
                // write keeps presenting the same word.
                WRITE: begin
                    if (mem_req_o && mem_gnt_i) begin
                        if (count == last) begin
`ifdef FLASH_ERASE_VERIFY_EN
                            mem_we_o   <= 1'b0;
                            mem_addr_o <= base;
                            count      <= '0;
                            chk_valid  <= 1'b0;
                            chk_last   <= 1'b0;
                            state      <= VERIFY;
`else
                            mem_req_q <= 1'b0;
                            mem_we_o  <= 1'b0;
                            done_o    <= 1'b1;
                            state     <= DONE;
`endif
                        end else begin
                            count      <= count_inc;
                            mem_addr_o <= base + count_inc[AddrW-1:0];
                        end
                    end
                end

`ifdef FLASH_ERASE_VERIFY_EN
                // Reads are pipelined one deep: each granted read is checked
                // on the following edge while the next read is offered.
                VERIFY: begin
                    chk_valid <= 1'b0;
                    chk_last  <= 1'b0;
                    if (rd_fail) begin
                        mem_req_q <= 1'b0;
                        err_o     <= 1'b1;
                        state     <= ERR;
                    end else if (chk_valid && chk_last) begin
                        done_o <= 1'b1;
                        state  <= DONE;
                    end else if (mem_req_o && mem_gnt_i) begin
                        chk_valid <= 1'b1;
                        chk_last  <= (count == last);
                        if (count == last) begin
                            mem_req_q <= 1'b0;
                        end else begin
                            count      <= count_inc;
                            mem_addr_o <= base + count_inc[AddrW-1:0];
                        end
                    end
                end
`endif

                DONE: begin
                    state <= WAIT_REL;
                end

                ERR: begin
                    state <= WAIT_REL;
                end

                // A request that stays high after its pulse is never
                // treated as a fresh request.
                WAIT_REL: begin
                    if (!req_i) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
